// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for the register file / scoreboard: read ports, two write
// ports, the issue request and the status outputs.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;

    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;

    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ready;

    logic [ADDR_W:0]          busy_cnt;
    logic                     wr_conflict;

    // Requester side (pipeline front end / testbench)
    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ready, busy_cnt, wr_conflict
    );

    // Register file side
    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ready, busy_cnt, wr_conflict
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with write bypass and a per-register busy
// scoreboard for destination reservations. Write port 0 outranks port 1;
// a same-address double write keeps port 0 and raises a sticky flag.
module regfile_scoreboard #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter int                ZERO_REG = 1,
    parameter int                SP_IDX   = 29,
    parameter logic [DATA_W-1:0] SP_INIT  = 32'h7fff_effc
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    // Write qualification
    logic              wr0_eff;
    logic              wr1_eff;
    logic              wr_same;
    logic              wr1_commit;

    // Issue handling
    logic              iss_zero;
    logic              iss_hit;
    logic              iss_ready_w;
    logic              iss_acc;

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // A write only counts when enabled, out of reset and not aimed at a
    // hardwired zero register; everything downstream keys off these.
    assign wr0_eff = bus.wr0_en && !reset &&
                     ((ZERO_REG == 0) || (bus.wr0_addr != '0));
    assign wr1_eff = bus.wr1_en && !reset &&
                     ((ZERO_REG == 0) || (bus.wr1_addr != '0));
    assign wr_same    = wr0_eff && wr1_eff && (bus.wr0_addr == bus.wr1_addr);
    assign wr1_commit = wr1_eff && !wr_same;

    // Read ports: zero register, then wr0 bypass, then wr1 bypass, then array.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign zero = (ZERO_REG != 0) && (addr == '0);
        assign hit0 = wr0_eff && (bus.wr0_addr == addr);
        assign hit1 = wr1_eff && (bus.wr1_addr == addr);

        assign data = zero ? '0 :
                      hit0 ? bus.wr0_data :
                      hit1 ? bus.wr1_data :
                             regs_q[addr];

        // A register being written this cycle already reports not-busy.
        assign bsy  = !zero && busy_q[addr] && !hit0 && !hit1;

        assign bus.rd_data[k*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[k]                  = bsy;
    end

    // Issue is ready when the destination is free or is being freed now.
    assign iss_zero    = (ZERO_REG != 0) && (bus.iss_addr == '0);
    assign iss_hit     = (wr0_eff && (bus.wr0_addr == bus.iss_addr)) ||
                         (wr1_eff && (bus.wr1_addr == bus.iss_addr));
    assign iss_ready_w = !reset &&
                         (iss_zero || !busy_q[bus.iss_addr] || iss_hit);
    assign iss_acc     = bus.iss_en && iss_ready_w;

    // Next scoreboard: write clears first, so a same-cycle accepted issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr0_eff) begin
            busy_d[bus.wr0_addr] = 1'b0;
        end
        if (wr1_eff) begin
            busy_d[bus.wr1_addr] = 1'b0;
        end
        if (iss_acc && !iss_zero) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        busy_cnt_d    = popcount(busy_d);
        wr_conflict_d = wr_conflict_q | wr_same;
    end

    // Register array: reset image with the stack pointer preloaded, else commit writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            if (wr1_commit) begin
                regs_q[bus.wr1_addr] <= bus.wr1_data;
            end
            if (wr0_eff) begin
                regs_q[bus.wr0_addr] <= bus.wr0_data;
            end
        end
    end

    // Scoreboard, reservation count and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q        <= '0;
            busy_cnt_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            busy_cnt_q    <= busy_cnt_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign bus.iss_ready   = iss_ready_w;
    assign bus.busy_cnt    = busy_cnt_q;
    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run against a behavioural register/scoreboard model.
module tb_regfile_scoreboard;
    localparam int          DATA_W  = 32;
    localparam int          ADDR_W  = 5;
    localparam int          NUM_RD  = 2;
    localparam int          NREGS   = 32;
    localparam logic [31:0] SP_INIT = 32'h7fff_effc;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .ZERO_REG(1), .SP_IDX(29), .SP_INIT(SP_INIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    logic [31:0]      m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_conf;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic m_eff0();
        return bus.wr0_en && !reset && (bus.wr0_addr != 5'd0);
    endfunction

    function automatic logic m_eff1();
        return bus.wr1_en && !reset && (bus.wr1_addr != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0)                         return 32'd0;
        if (m_eff0() && bus.wr0_addr == a)     return bus.wr0_data;
        if (m_eff1() && bus.wr1_addr == a)     return bus.wr1_data;
        return m_regs[a];
    endfunction

    function automatic logic m_writing(input logic [4:0] a);
        return (m_eff0() && bus.wr0_addr == a) || (m_eff1() && bus.wr1_addr == a);
    endfunction

    function automatic logic m_ready(input logic [4:0] a);
        if (reset)      return 1'b0;
        if (a == 5'd0)  return 1'b1;
        return !m_busy[a] || m_writing(a);
    endfunction

    function automatic logic m_rdbusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return m_busy[a] && !m_writing(a);
    endfunction

    task automatic idle();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    // Advance one clock and move the model by the same rules.
    task automatic tick();
        logic [31:0]      nr [NREGS];
        logic [NREGS-1:0] nb;
        logic             nc;
        nr = m_regs;
        nb = m_busy;
        nc = m_conf;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) nr[i] = 32'd0;
            nr[29] = SP_INIT;
            nb = '0;
            nc = 1'b0;
        end else begin
            if (m_eff0() && m_eff1() && bus.wr0_addr == bus.wr1_addr) nc = 1'b1;
            if (m_eff1()) nr[bus.wr1_addr] = bus.wr1_data;
            if (m_eff0()) nr[bus.wr0_addr] = bus.wr0_data;
            if (m_eff0()) nb[bus.wr0_addr] = 1'b0;
            if (m_eff1()) nb[bus.wr1_addr] = 1'b0;
            if (bus.iss_en && m_ready(bus.iss_addr) && bus.iss_addr != 5'd0)
                nb[bus.iss_addr] = 1'b1;
        end
        @(posedge clk);
        m_regs = nr;
        m_busy = nb;
        m_conf = nc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_rd(0, 5'd29);
        set_rd(1, 5'd5);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd5;
        #1;
        n_total++;
        if (bus.iss_ready !== 1'b0) $display("FAIL reset_iss_ready: got %b expected 0", bus.iss_ready);
        else n_pass++;
        tick();
        // Writes during reset must not bypass or commit.
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd29; bus.wr0_data = 32'h1234_5678;
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== SP_INIT) $display("FAIL reset_no_bypass: got %h expected %h", bus.rd_data[31:0], SP_INIT);
        else n_pass++;
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'h7fff_effc) $display("FAIL reset_sp: got %h expected 7fffeffc", bus.rd_data[31:0]);
        else n_pass++;
        n_total++;
        if (bus.rd_data[63:32] !== 32'd0) $display("FAIL reset_r5: got %h expected 0", bus.rd_data[63:32]);
        else n_pass++;
        n_total++;
        if (bus.busy_cnt !== 6'd0) $display("FAIL reset_busy_cnt: got %0d expected 0", bus.busy_cnt);
        else n_pass++;
        n_total++;
        if (bus.wr_conflict !== 1'b0) $display("FAIL reset_conflict: got %b expected 0", bus.wr_conflict);
        else n_pass++;
    endtask

    task automatic test_bypass();
        idle();
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'hA5A5_0001;
        set_rd(0, 5'd7);
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'hA5A5_0001) $display("FAIL bypass_same_cycle: got %h expected a5a50001", bus.rd_data[31:0]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'hA5A5_0001) $display("FAIL bypass_stored: got %h expected a5a50001", bus.rd_data[31:0]);
        else n_pass++;
    endtask

    task automatic test_conflict();
        idle();
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd3; bus.wr1_data = 32'h22;
        set_rd(1, 5'd3);
        #1;
        n_total++;
        if (bus.rd_data[63:32] !== 32'h11) $display("FAIL conflict_bypass: got %h expected 11", bus.rd_data[63:32]);
        else n_pass++;
        n_total++;
        if (bus.wr_conflict !== 1'b0) $display("FAIL conflict_early: got %b expected 0", bus.wr_conflict);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.rd_data[63:32] !== 32'h11) $display("FAIL conflict_stored: got %h expected 11", bus.rd_data[63:32]);
        else n_pass++;
        n_total++;
        if (bus.wr_conflict !== 1'b1) $display("FAIL conflict_set: got %b expected 1", bus.wr_conflict);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (bus.wr_conflict !== 1'b1) $display("FAIL conflict_sticky: got %b expected 1", bus.wr_conflict);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        #1;
        n_total++;
        if (bus.iss_ready !== 1'b1) $display("FAIL sb_first_ready: got %b expected 1", bus.iss_ready);
        else n_pass++;
        tick();
        idle();
        set_rd(1, 5'd9);
        #1;
        n_total++;
        if (bus.busy_cnt !== 6'd1) $display("FAIL sb_cnt_after_issue: got %0d expected 1", bus.busy_cnt);
        else n_pass++;
        n_total++;
        if (bus.rd_busy[1] !== 1'b1) $display("FAIL sb_rd_busy: got %b expected 1", bus.rd_busy[1]);
        else n_pass++;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        #1;
        n_total++;
        if (bus.iss_ready !== 1'b0) $display("FAIL sb_reissue_ready: got %b expected 0", bus.iss_ready);
        else n_pass++;
        tick();
        bus.iss_en = 1'b0;
        #1;
        n_total++;
        if (bus.busy_cnt !== 6'd1) $display("FAIL sb_reissue_cnt: got %0d expected 1", bus.busy_cnt);
        else n_pass++;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h5;
        #1;
        n_total++;
        if (bus.iss_ready !== 1'b1) $display("FAIL sb_ready_on_write: got %b expected 1", bus.iss_ready);
        else n_pass++;
        n_total++;
        if (bus.rd_busy[1] !== 1'b0) $display("FAIL sb_rd_busy_clear: got %b expected 0", bus.rd_busy[1]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.busy_cnt !== 6'd0) $display("FAIL sb_cnt_cleared: got %0d expected 0", bus.busy_cnt);
        else n_pass++;
        n_total++;
        if (bus.rd_data[63:32] !== 32'h5) $display("FAIL sb_r9_data: got %h expected 5", bus.rd_data[63:32]);
        else n_pass++;
    endtask

    task automatic test_issue_write_same();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        tick();
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd4; bus.wr0_data = 32'hBEEF_0004;
        #1;
        n_total++;
        if (bus.iss_ready !== 1'b1) $display("FAIL iw_ready: got %b expected 1", bus.iss_ready);
        else n_pass++;
        tick();
        idle();
        set_rd(0, 5'd4);
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'hBEEF_0004) $display("FAIL iw_data: got %h expected beef0004", bus.rd_data[31:0]);
        else n_pass++;
        n_total++;
        if (bus.rd_busy[0] !== 1'b1) $display("FAIL iw_still_busy: got %b expected 1", bus.rd_busy[0]);
        else n_pass++;
        n_total++;
        if (bus.busy_cnt !== 6'd1) $display("FAIL iw_cnt: got %0d expected 1", bus.busy_cnt);
        else n_pass++;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd4; bus.wr0_data = 32'h4;
        tick();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF_FFFF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'd0) $display("FAIL zero_bypass: got %h expected 0", bus.rd_data[31:0]);
        else n_pass++;
        n_total++;
        if (bus.iss_ready !== 1'b1) $display("FAIL zero_ready: got %b expected 1", bus.iss_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.rd_data[31:0] !== 32'd0 || bus.rd_busy[0] !== 1'b0 || bus.busy_cnt !== 6'd0)
            $display("FAIL zero_after: got data %h busy %b cnt %0d expected 0 0 0",
                     bus.rd_data[31:0], bus.rd_busy[0], bus.busy_cnt);
        else n_pass++;
        for (int r = 10; r < 13; r++) begin
            bus.iss_en = 1'b1; bus.iss_addr = 5'(r);
            tick();
        end
        idle();
        #1;
        n_total++;
        if (bus.busy_cnt !== 6'd3) $display("FAIL three_busy: got %0d expected 3", bus.busy_cnt);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.busy_cnt !== 6'd0 || bus.wr_conflict !== 1'b0)
            $display("FAIL mid_reset: got cnt %0d conflict %b expected 0 0", bus.busy_cnt, bus.wr_conflict);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 39) == 0);
            bus.wr0_en   = $urandom_range(0, 1) == 1;
            bus.wr0_addr = 5'($urandom_range(0, 7));
            bus.wr0_data = $urandom;
            bus.wr1_en   = $urandom_range(0, 2) == 0;
            bus.wr1_addr = 5'($urandom_range(0, 7));
            bus.wr1_data = $urandom;
            bus.iss_en   = $urandom_range(0, 1) == 1;
            bus.iss_addr = 5'($urandom_range(0, 7));
            set_rd(0, 5'($urandom_range(0, 7)));
            set_rd(1, (c % 5 == 0) ? 5'd29 : 5'($urandom_range(0, 7)));
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                logic [4:0] a;
                a = bus.rd_addr[k*ADDR_W +: ADDR_W];
                n_total++;
                if (bus.rd_data[k*DATA_W +: DATA_W] !== m_read(a))
                    $display("FAIL rand_rd_data[%0d] cyc %0d addr %0d: got %h expected %h",
                             k, c, a, bus.rd_data[k*DATA_W +: DATA_W], m_read(a));
                else n_pass++;
                n_total++;
                if (bus.rd_busy[k] !== m_rdbusy(a))
                    $display("FAIL rand_rd_busy[%0d] cyc %0d addr %0d: got %b expected %b",
                             k, c, a, bus.rd_busy[k], m_rdbusy(a));
                else n_pass++;
            end
            n_total++;
            if (bus.iss_ready !== m_ready(bus.iss_addr))
                $display("FAIL rand_iss_ready cyc %0d: got %b expected %b", c, bus.iss_ready, m_ready(bus.iss_addr));
            else n_pass++;
            tick();
            n_total++;
            if (bus.busy_cnt !== 6'($countones(m_busy)))
                $display("FAIL rand_busy_cnt cyc %0d: got %0d expected %0d", c, bus.busy_cnt, $countones(m_busy));
            else n_pass++;
            n_total++;
            if (bus.wr_conflict !== m_conf)
                $display("FAIL rand_conflict cyc %0d: got %b expected %b", c, bus.wr_conflict, m_conf);
            else n_pass++;
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset       = 1'b1;
        bus.rd_addr = '0;
        idle();
        test_reset();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_issue_write_same();
        test_zero_reg();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, index width; register count NREGS = 2^ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (range 1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-005 SHALL have parameters SP_IDX, default 29, and SP_INIT, default 32'h7fff_effc: the register index and value loaded at reset.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports rd_addr  input  NUM_RD*ADDR_W, rd_data  output  NUM_RD*DATA_W, rd_busy  output  NUM_RD; port k occupies slice k.
REQ-009 SHALL have ports wr0_en  input  1, wr0_addr  input  ADDR_W, wr0_data  input  DATA_W: write port 0, the higher-priority port.
REQ-010 SHALL have ports wr1_en  input  1, wr1_addr  input  ADDR_W, wr1_data  input  DATA_W: write port 1, the lower-priority port.
REQ-011 SHALL have ports iss_en  input  1, iss_addr  input  ADDR_W, iss_ready  output  1: destination-reservation request.
REQ-012 SHALL have ports busy_cnt  output  ADDR_W+1 (number of reserved registers) and wr_conflict  output  1 (sticky error flag).

Function
REQ-013 Effective write: wrN_en=1, reset=0, and (ZERO_REG=0 or wrN_addr!=0).
REQ-014 Both ports write the same address in one cycle: wr0 SHALL be stored, wr1 SHALL be dropped, and wr_conflict SHALL be set on the next edge; it stays set until reset.
REQ-015 Distinct-address writes on both ports in one cycle SHALL both commit on the same edge.
REQ-016 Read k SHALL be combinational, with priority: ZERO_REG=1 and addr 0 -> 0; else effective wr0 to the same address -> wr0_data; else effective wr1 to the same address -> wr1_data; else the stored value.
REQ-017 Scoreboard SHALL hold one busy bit per register; busy[0] SHALL never set when ZERO_REG=1.
REQ-018 iss_ready SHALL be 1 iff busy[iss_addr]=0, or an effective write to iss_addr occurs this cycle; ZERO_REG=1 with iss_addr=0 SHALL always be ready.
REQ-019 iss_en=1 with iss_ready=1 SHALL set busy[iss_addr] on the edge; iss_en=1 with iss_ready=0 SHALL change nothing.
REQ-020 An effective write SHALL clear busy[addr] on the edge, unless an accepted issue targets the same address in the same cycle, in which case busy stays 1.
REQ-021 rd_busy[k] SHALL be busy[rd_addr_k] with the same-cycle write clear applied; it SHALL be 0 for register 0 when ZERO_REG=1.
REQ-022 A write to a non-busy register SHALL commit normally and leave busy at 0.
REQ-023 busy_cnt SHALL be a registered count equal to the popcount of busy, updated on the same edge as busy; net change per cycle is -2..+1.

Reset
REQ-024 With reset=1 at an edge: all registers SHALL become 0, except SP_IDX, which SHALL become SP_INIT; busy SHALL be all-0; busy_cnt SHALL be 0; wr_conflict SHALL be 0.
REQ-025 While reset=1: writes and issues SHALL be ignored, bypass SHALL be disabled, iss_ready SHALL be 0, and reads SHALL return stored contents.
REQ-026 Reset asserted mid-operation SHALL discard all outstanding reservations; there are no partial updates.

Verification
REQ-027 Reset, then read addr 29 and addr 5 -> 32'h7fff_effc and 0; busy_cnt=0; wr_conflict=0.
REQ-028 wr0 to r7=0xA5A5_0001 while port 0 reads r7 in the same cycle -> rd_data0=0xA5A5_0001 that cycle; next cycle, from the array, the same value.
REQ-029 wr0 r3=0x11 and wr1 r3=0x22 in the same cycle -> r3 reads 0x11; wr_conflict=1 from the next cycle until reset.
REQ-030 Issue r9 -> busy_cnt=1 and rd_busy for r9 =1; a re-issue of r9 gives iss_ready=0 with no change; wr1 r9=0x5 -> iss_ready=1 in that cycle, busy clears, busy_cnt=0.
REQ-031 Issue r4 together with a write to r4 in the same cycle -> r4 data updated, busy[4] stays 1, busy_cnt unchanged.
REQ-032 Write and issue r0 with ZERO_REG=1 -> reads 0, rd_busy=0, busy_cnt=0; reset asserted with 3 registers busy -> busy_cnt=0 next cycle.
